// File: rtl/enemy_patrol_bank.sv
// Multi-enemy patrol engine: walks N ground enemies, reverses them at blocks and screen edges, resolves stomps and contact.
// Optional build macro ENEMY_EDGE_TURN_EN: enemies also turn around at ledges (tile under the leading foot not GND/BLK).
module enemy_patrol_bank #(
    parameter int                    N_ENEMIES       = 4,
    parameter int                    STEP            = 1,
    parameter int                    CHARACTER_WIDTH = 42,
    parameter int                    BLOCK_WIDTH     = 40,
    parameter int                    SCREEN_WIDTH    = 640,
    parameter logic [7:0]            BLK             = 8'd2,
    parameter logic [7:0]            GND             = 8'd3,
    parameter int                    OFFSCREEN_X     = 1000,
    parameter logic [N_ENEMIES-1:0]  START_DIR       = '1
) (
    input  logic                 movement_clock,
    input  logic                 reset,
    input  logic [7:0]           background [11:0][16:0],
    input  int                   mario_x,
    input  int                   mario_y,
    input  int                   start_x [N_ENEMIES],
    input  int                   enemy_y [N_ENEMIES],
    output int                   enemy_x [N_ENEMIES],
    output logic [N_ENEMIES-1:0] alive,
    output logic                 lose,
    output logic                 stomp_pulse,
    output logic [7:0]           stomp_count
);

`ifdef ENEMY_EDGE_TURN_EN
    localparam bit EDGE_TURN = 1'b1;
`else
    localparam bit EDGE_TURN = 1'b0;
`endif

    localparam int CW = CHARACTER_WIDTH;
    localparam int BW = BLOCK_WIDTH;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_LOSE} state_t;

    state_t                 state, next_state;
    logic [N_ENEMIES-1:0]   move_right;
    logic [N_ENEMIES-1:0]   stomp, contact, next_right;
    int                     moved_x [N_ENEMIES];
    logic                   any_contact;
    logic [7:0]             count_sum;

    // Rows clamp into the map; columns outside it never match any tile code.
    function automatic logic is_tile(input int row, input int col, input logic [7:0] code);
        int r;
        r = (row < 0) ? 0 : ((row > 11) ? 11 : row);
        if (col < 0 || col > 16) return 1'b0;
        return background[4'(r)][5'(col)] == code;
    endfunction

    always_comb begin
        int   x, y, lead_col, top_row, bot_row, foot_row;
        logic overlap, wall, ledge;
        x = 0; y = 0; lead_col = 0; top_row = 0; bot_row = 0; foot_row = 0;
        overlap = 1'b0; wall = 1'b0; ledge = 1'b0;
        stomp      = '0;
        contact    = '0;
        next_right = move_right;
        for (int i = 0; i < N_ENEMIES; i++) begin
            x        = enemy_x[i];
            y        = enemy_y[i];
            overlap  = (mario_x + CW >= x) && (mario_x <= x + CW);
            stomp[i] = alive[i] && overlap && (mario_y + CW == y);
            contact[i] = alive[i] && overlap && !stomp[i]
                         && (mario_y + CW > y) && (mario_y <= y + CW);

            lead_col = move_right[i] ? (x + CW + STEP - 1) / BW : (x - STEP) / BW;
            top_row  = y / BW;
            bot_row  = (y + CW - 1) / BW;
            foot_row = (y + CW) / BW;
            wall = is_tile(top_row, lead_col, BLK) || is_tile(bot_row, lead_col, BLK)
                   || (move_right[i] ? (x + CW + STEP > SCREEN_WIDTH) : (x - STEP < 0));
            ledge = EDGE_TURN && (foot_row <= 11)
                    && !(is_tile(foot_row, lead_col, GND) || is_tile(foot_row, lead_col, BLK));

            // The reversal and the first step in the new direction land on the same edge.
            next_right[i] = move_right[i] ^ (wall || ledge);
            moved_x[i]    = next_right[i] ? x + STEP : x - STEP;
        end
        any_contact = |contact;
    end

    always_comb begin
        int total;
        total     = int'(stomp_count) + $countones(stomp);
        count_sum = (total > 255) ? 8'hFF : 8'(total);
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:  next_state = S_RUN;
            S_RUN:   if (any_contact) next_state = S_LOSE;
            default: next_state = S_LOSE;
        endcase
    end

    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) state <= S_INIT;
        else        state <= next_state;
    end

    // NOTE: the position array is a handful of registers, not a RAM, so it is cleared by reset like the rest.
    always_ff @(posedge movement_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENEMIES; i++) enemy_x[i] <= 0;
            alive       <= '0;
            move_right  <= START_DIR;
            lose        <= 1'b0;
            stomp_pulse <= 1'b0;
            stomp_count <= 8'd0;
        end else begin
            lose        <= (next_state == S_LOSE);
            stomp_pulse <= 1'b0;
            case (state)
                S_INIT: begin
                    for (int i = 0; i < N_ENEMIES; i++) enemy_x[i] <= start_x[i];
                    alive <= '1;
                end
                S_RUN: begin
                    // A contact anywhere freezes the whole bank and voids this edge's stomps.
                    if (!any_contact) begin
                        for (int i = 0; i < N_ENEMIES; i++) begin
                            if (stomp[i]) begin
                                enemy_x[i] <= OFFSCREEN_X;
                            end else if (alive[i]) begin
                                enemy_x[i]    <= moved_x[i];
                                move_right[i] <= next_right[i];
                            end
                        end
                        alive       <= alive & ~stomp;
                        stomp_pulse <= |stomp;
                        stomp_count <= count_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
